adc_window_integrator: RTL

//  Downstream of subsystem_adc, on clk: sums each ADC channel over a programmable window of sample_valid strobes.
//  At each window close it emits one 64-bit AXI-stream packet: header, first-sample timestamp, NUM_CH sums.

---
 rtl/adc_window_integrator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adc_window_integrator.sv
// Per-channel windowed integrator: sums each ADC channel over window_len strobes and
// streams {header, first timestamp, sums} as a 64-bit AXI-stream packet, double-buffered.

module adc_window_lane #(
  parameter int WIDTH = 18,
  parameter int SUM_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ch_valid,
  output logic [SUM_W-1:0] buf_sum,
  output logic             buf_bad
);
  logic [SUM_W-1:0] sum, sum_nxt, d_ext;
  logic             bad, bad_nxt;

  // The opening sample replaces the old window's sum instead of adding to it.
  assign d_ext   = ch_valid ? {{(SUM_W-WIDTH){data[WIDTH-1]}}, data} : '0;
  assign sum_nxt = (start ? '0 : sum) + d_ext;
  assign bad_nxt = (bad & ~start) | ~ch_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      bad     <= 1'b0;
      buf_sum <= '0;
      buf_bad <= 1'b0;
    end else begin
      if (acc) begin
        sum <= sum_nxt;
        bad <= bad_nxt;
      end
      // Load captures the closing strobe's contribution directly.
      if (load) begin
        buf_sum <= sum_nxt;
        buf_bad <= bad_nxt;
      end
    end
  end
endmodule

module adc_window_integrator #(
  parameter int NUM_CH   = 16,
  parameter int WIDTH    = 18,
  parameter int CNT_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic [CNT_BITS-1:0]            window_len,
  input  logic                           sample_valid,
  input  logic [63:0]                    sample_ts,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   sample_ch_data,
  input  logic [NUM_CH-1:0]              sample_ch_valid,
  output logic [63:0]                    fifo_tdata,
  output logic                           fifo_tvalid,
  output logic                           fifo_tlast,
  input  logic                           fifo_tready,
  output logic [15:0]                    overflow_count,
  output logic                           busy
);
  localparam int SUM_W = WIDTH + CNT_BITS;
  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH-1);

  localparam logic [0:0] A_IDLE  = 1'd0;
  localparam logic [0:0] A_ACCUM = 1'd1;
  localparam logic [1:0] E_IDLE  = 2'd0;
  localparam logic [1:0] E_HDR   = 2'd1;
  localparam logic [1:0] E_TS    = 2'd2;
  localparam logic [1:0] E_SUM   = 2'd3;

  typedef struct packed {
    logic [CNT_BITS-1:0] n;
    logic [63:0]         ts;
  } hdr_t;

  logic [0:0]                     acc_st;
  logic [CNT_BITS-1:0]            cnt, n_len, cnt_nxt, n_cur;
  logic [63:0]                    ts0;
  logic                           start, step, acc, close;
  logic [1:0]                     e_st;
  logic [IW-1:0]                  widx;
  hdr_t                           hdr;
  logic                           hs, last_hs, em_free, load;
  logic [NUM_CH-1:0][SUM_W-1:0]   buf_sum;
  logic [NUM_CH-1:0]              buf_bad;

  assign start   = (acc_st == A_IDLE) && ena && (window_len != '0) && sample_valid;
  assign step    = (acc_st == A_ACCUM) && ena && sample_valid;
  assign acc     = start | step;
  assign cnt_nxt = start ? CNT_BITS'(1) : cnt + CNT_BITS'(1);
  assign n_cur   = start ? window_len : n_len;
  assign close   = acc && (cnt_nxt == n_cur);
  assign busy    = (acc_st == A_ACCUM);

  assign fifo_tvalid = (e_st != E_IDLE);
  assign fifo_tlast  = (e_st == E_SUM) && (widx == LAST_IDX);
  assign hs          = fifo_tvalid && fifo_tready;
  assign last_hs     = hs && fifo_tlast;
  // A close that lands on the final handshake reuses the buffer without a gap.
  assign em_free     = (e_st == E_IDLE) || last_hs;
  assign load        = close && em_free;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    adc_window_lane #(.WIDTH(WIDTH), .SUM_W(SUM_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .acc      (acc),
      .load     (load),
      .data     (sample_ch_data[k]),
      .ch_valid (sample_ch_valid[k]),
      .buf_sum  (buf_sum[k]),
      .buf_bad  (buf_bad[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_st <= A_IDLE;
      cnt    <= '0;
      n_len  <= '0;
      ts0    <= '0;
    end else begin
      case (acc_st)
        A_IDLE: if (start) begin
          n_len  <= window_len;
          ts0    <= sample_ts;
          cnt    <= cnt_nxt;
          acc_st <= close ? A_IDLE : A_ACCUM;
        end
        default: if (!ena) begin
          acc_st <= A_IDLE;
        end else if (sample_valid) begin
          cnt <= cnt_nxt;
          if (close) acc_st <= A_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_st           <= E_IDLE;
      widx           <= '0;
      hdr            <= '0;
      overflow_count <= '0;
    end else begin
      if (load) begin
        hdr.n  <= n_cur;
        hdr.ts <= start ? sample_ts : ts0;
        e_st   <= E_HDR;
        widx   <= '0;
      end else if (hs) begin
        case (e_st)
          E_HDR: e_st <= E_TS;
          E_TS: begin
            e_st <= E_SUM;
            widx <= '0;
          end
          E_SUM: if (fifo_tlast) e_st <= E_IDLE;
                 else            widx <= widx + IW'(1);
          default: e_st <= E_IDLE;
        endcase
      end
      if (close && !em_free && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  always_comb begin
    fifo_tdata = '0;
    case (e_st)
      E_HDR: fifo_tdata = {8'hA1, 8'(NUM_CH), 16'(hdr.n), 32'(buf_bad)};
      E_TS:  fifo_tdata = hdr.ts;
      E_SUM: fifo_tdata = 64'($signed(buf_sum[widx]));
      default: fifo_tdata = '0;
    endcase
  end
endmodule
